// File: rtl/xnorfa_dot_seq.sv
// XNOR-popcount dot-product sequencer: streams 3-bit a/w groups through one
// single_xnorfa cell, accumulates match counts, reports popcount and sign.
// Optional macro XNORFA_THRESH_EN adds a programmable sign threshold port.

module single_xnorfa (
  input  logic [2:0] a,
  input  logic [2:0] w,
  output logic [1:0] m
);
  logic [2:0] x;

  // Full adder over the three XNOR match bits: {carry, sum} is the match count.
  assign x = ~(a ^ w);
  assign m = {(x[0] & x[1]) | (x[2] & (x[0] ^ x[1])), x[0] ^ x[1] ^ x[2]};
endmodule

module xnorfa_dot_seq #(
  parameter  int N_GROUPS = 4,
  localparam int ACC_W    = $clog2(3*N_GROUPS+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       a,
  input  logic [2:0]       w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] popcount,
  output logic             sign
`ifdef XNORFA_THRESH_EN
  ,
  input  logic [ACC_W-1:0] thresh
`endif
);

  localparam int CNT_W = $clog2(N_GROUPS+1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  grp_cnt;
  logic [2:0]        a_q, w_q;
  logic              v1, v2;
  logic [1:0]        m, m_q;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic              hs, last_grp, start_acc, finish, sign_nxt;

  single_xnorfa u_cell (.a(a_q), .w(w_q), .m(m));

  assign hs        = in_valid && (state == RUN);
  assign last_grp  = (grp_cnt == CNT_W'(N_GROUPS-1));
  assign start_acc = start && (state == IDLE);
  // Leaving DRAIN coincides with the final add, so results latch acc_nxt.
  assign finish    = (state == DRAIN) && !v1;
  assign acc_nxt   = v2 ? acc + ACC_W'(m_q) : acc;

`ifdef XNORFA_THRESH_EN
  logic [ACC_W-1:0] thresh_q;

  assign sign_nxt = (acc_nxt >= thresh_q);

  always_ff @(posedge clk) begin
    if (!rst_n)         thresh_q <= '0;
    else if (start_acc) thresh_q <= thresh;
  end
`else
  assign sign_nxt = (2 * int'(acc_nxt)) > (3 * N_GROUPS);
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=) with defaults first.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)          state_nxt = RUN;
      RUN:     if (hs && last_grp) state_nxt = DRAIN;
      DRAIN:   if (!v1)            state_nxt = DONE;
      DONE:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the decode so no latch is inferred.
  always_comb begin
    busy      = 1'b1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    busy      = 1'b0;
      RUN:     in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grp_cnt <= '0;
      a_q     <= '0;
      w_q     <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      m_q     <= '0;
      acc     <= '0;
    end else if (start_acc) begin
      grp_cnt <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      acc     <= '0;
    end else begin
      v1  <= hs;
      v2  <= v1;
      acc <= acc_nxt;
      if (hs) begin
        a_q     <= a;
        w_q     <= w;
        grp_cnt <= grp_cnt + 1'b1;
      end
      if (v1) m_q <= m;
    end
  end

  // Result registers hold through IDLE until the next dot product completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      popcount <= '0;
      sign     <= 1'b0;
    end else if (finish) begin
      popcount <= acc_nxt;
      sign     <= sign_nxt;
    end
  end

endmodule

// File: tb/tb_xnorfa_dot_seq.sv
// Directed self-checking bench for xnorfa_dot_seq with N_GROUPS=4.
// Build with XNORFA_THRESH_EN defined to also exercise the threshold port.

module tb_xnorfa_dot_seq;
  localparam int N_GROUPS = 4;
  localparam int ACC_W    = $clog2(3*N_GROUPS+1);

  logic             clk = 1'b0;
  logic             rst_n, start, busy, in_valid, in_ready;
  logic [2:0]       a, w;
  logic             out_valid, out_ready, sign;
  logic [ACC_W-1:0] popcount;
  logic [ACC_W-1:0] thresh;

  int n_checks = 0;
  int n_fail   = 0;

  xnorfa_dot_seq #(.N_GROUPS(N_GROUPS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .w(w),
    .out_valid(out_valid), .out_ready(out_ready),
    .popcount(popcount), .sign(sign)
`ifdef XNORFA_THRESH_EN
    , .thresh(thresh)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled and inputs driven 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_dot(input string tag, input logic [3:0][2:0] av,
                         input logic [3:0][2:0] wv, input bit bubbles,
                         input int exp_pc, input bit exp_sign);
    int n;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int g = 0; g < N_GROUPS; g++) begin
      in_valid = 1'b1;
      a = av[g];
      w = wv[g];
      step();
      in_valid = 1'b0;
      if (bubbles) step();
    end
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_done"}, out_valid, 1);
    check({tag, "_pc"}, popcount, exp_pc);
    check({tag, "_sign"}, sign, exp_sign);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; w = '0;
    thresh = ACC_W'(7);  // matches the default majority rule (2*acc > 12)
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_popcount", popcount, 0);
    check("rst_sign", sign, 0);
    rst_n = 1'b1;
    step();

    // Back-to-back all-match groups with exact latency check.
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_in_ready", in_ready, 1);
    in_valid = 1'b1; a = 3'b101; w = 3'b101;
    for (int g = 0; g < N_GROUPS; g++) step();
    in_valid = 1'b0;
    check("t1_in_ready_low", in_ready, 0);
    check("t1_ov_e5", out_valid, 0);
    step();
    check("t1_ov_e5b", out_valid, 0);
    step();
    check("t1_ov_e6", out_valid, 1);
    check("t1_pc", popcount, 12);
    check("t1_sign", sign, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1_idle_busy", busy, 0);
    check("t1_idle_ov", out_valid, 0);
    check("t1_hold_pc", popcount, 12);
    check("t1_hold_sign", sign, 1);

    // No matches, bubbles between groups, extra in_valid after last group.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int g = 0; g < N_GROUPS; g++) begin
      in_valid = 1'b1; a = 3'b000; w = 3'b111;
      step();
      in_valid = 1'b0;
      if (g == N_GROUPS-1) check("t2_in_ready_low", in_ready, 0);
      step();
    end
    in_valid = 1'b1; a = 3'b111; w = 3'b111;
    begin
      int n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
    end
    in_valid = 1'b0;
    check("t2_done", out_valid, 1);
    check("t2_pc", popcount, 0);
    check("t2_sign", sign, 0);

    // Stall in DONE: outputs stable, start ignored.
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t2_stall_ov", out_valid, 1);
      check("t2_stall_busy", busy, 1);
      check("t2_stall_pc", popcount, 0);
      check("t2_stall_in_ready", in_ready, 0);
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t2_release_busy", busy, 0);
    check("t2_release_ov", out_valid, 0);

    // Tie case: matches 3,3,0,0 -> 6, not strictly above 6.
    run_dot("t3_tie", {3'b110, 3'b101, 3'b000, 3'b111},
            {3'b001, 3'b010, 3'b000, 3'b111}, 1'b0, 6, 1'b0);
    // Matches 3,3,3,0 -> 9, majority.
    run_dot("t3_nine", {3'b110, 3'b010, 3'b000, 3'b111},
            {3'b001, 3'b010, 3'b000, 3'b111}, 1'b1, 9, 1'b1);

    // Reset mid-run discards in-flight groups.
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1; a = 3'b011; w = 3'b011;
    step(); step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check("t4_rst_busy", busy, 0);
    check("t4_rst_in_ready", in_ready, 0);
    check("t4_rst_ov", out_valid, 0);
    check("t4_rst_pc", popcount, 0);
    check("t4_rst_sign", sign, 0);
    rst_n = 1'b1;
    step();
    run_dot("t4_fresh", {4{3'b010}}, {4{3'b010}}, 1'b0, 12, 1'b1);

    // Matches 2,1,1,1 -> 5.
`ifdef XNORFA_THRESH_EN
    thresh = ACC_W'(5);
    run_dot("t5_th5", {4{3'b000}}, {3'b011, 3'b011, 3'b011, 3'b001}, 1'b0, 5, 1'b1);
    thresh = ACC_W'(6);
    run_dot("t5_th6", {4{3'b000}}, {3'b011, 3'b011, 3'b011, 3'b001}, 1'b0, 5, 1'b0);
`else
    run_dot("t5_five", {4{3'b000}}, {3'b011, 3'b011, 3'b011, 3'b001}, 1'b0, 5, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
